// File: rtl/count_cmd_sched_pkg.sv
// count_ctrl_pkg: shared types and helpers for the counter command scheduler.
//   CNT_W    : width of the external up/down counter
//   op_e     : requester command encoding
//   state_e  : scheduler FSM states
//   cnt_next : value the counter takes on the next edge for given pin levels
package count_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] cnt_next(
    input logic             ld,
    input logic [CNT_W-1:0] d,
    input logic             up,
    input logic [CNT_W-1:0] cur
  );
    if (ld) return d;
    return up ? cur + CNT_W'(1) : cur - CNT_W'(1);
  endfunction

endpackage

// File: rtl/count_cmd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among a request vector.
//   req   in  NREQ  request vector
//   ptr   in  IDW   index where the search starts
//   grant out NREQ  one-hot winner (all zero when no request)
//   idx   out IDW   winner index
//   found out 1     any request present
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    found
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
    end
  end

endmodule

// File: rtl/count_cmd_sched.sv
// count_cmd_sched: round-robin command scheduler driving a 4-bit loadable
// up/down counter, with a shadow copy of the count for divergence detection.
//   clock, resetn            clock / synchronous active-low reset
//   req_valid/req_ready      per-requester handshake (ready one-hot, IDLE only)
//   req_op/req_data/req_steps per-requester command payload
//   load/up_down/data_in     registered counter control pins
//   count                    counter value fed back
//   done_valid/id/count      registered one-cycle completion report
//   busy                     high while executing a command
//   mismatch                 sticky count/shadow divergence flag
module count_cmd_sched
  import count_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int STEPW = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [CNT_W*NREQ-1:0]   req_data,
  input  logic [STEPW*NREQ-1:0]   req_steps,
  output logic                    load,
  output logic                    up_down,
  output logic [CNT_W-1:0]        data_in,
  input  logic [CNT_W-1:0]        count,
  output logic                    done_valid,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0]        done_count,
  output logic                    busy,
  output logic                    mismatch
);

  localparam int IDW = $clog2(NREQ);

  state_e            state, state_d;
  logic [STEPW-1:0]  steps_q, steps_d;
  logic [CNT_W-1:0]  shadow, shadow_d;
  logic [IDW-1:0]    ptr, ptr_d;
  logic [IDW-1:0]    cur_id, cur_id_d;

  logic              load_d, up_down_d, done_valid_d;
  logic [CNT_W-1:0]  data_in_d, done_count_d;
  logic [IDW-1:0]    done_id_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    win_idx;
  logic              win_found;
  op_e               sel_op;
  logic [CNT_W-1:0]  sel_data;
  logic [STEPW-1:0]  sel_steps;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    sel_op    = OP_NOP;
    sel_data  = '0;
    sel_steps = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_op    = op_e'(req_op[2*i +: 2]);
        sel_data  = req_data[CNT_W*i +: CNT_W];
        sel_steps = req_steps[STEPW*i +: STEPW];
      end
    end
  end

  // Shadow follows the registered pins exactly as the counter will on this edge.
  assign shadow_d = cnt_next(load, data_in, up_down, shadow);
  assign busy     = (state == S_EXEC);

  always_comb begin
    state_d      = state;
    steps_d      = steps_q;
    ptr_d        = ptr;
    cur_id_d     = cur_id;
    load_d       = load;
    up_down_d    = up_down;
    data_in_d    = data_in;
    done_valid_d = 1'b0;
    done_id_d    = done_id;
    done_count_d = done_count;
    req_ready    = '0;

    unique case (state)
      S_IDLE: begin
        req_ready = grant;
        load_d    = 1'b1;
        data_in_d = shadow_d;
        if (win_found) begin
          ptr_d    = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          cur_id_d = win_idx;
          if (sel_op == OP_LOAD) begin
            // LOAD runs as a one-cycle EXEC with load held high.
            state_d   = S_EXEC;
            data_in_d = sel_data;
            steps_d   = STEPW'(1);
          end else if (sel_op != OP_NOP && sel_steps != '0) begin
            state_d   = S_EXEC;
            load_d    = 1'b0;
            up_down_d = (sel_op == OP_UP);
            steps_d   = sel_steps;
          end else begin
            done_valid_d = 1'b1;
            done_id_d    = win_idx;
            done_count_d = shadow_d;
          end
        end
      end
      S_EXEC: begin
        steps_d = steps_q - STEPW'(1);
        if (steps_q == STEPW'(1)) begin
          state_d      = S_IDLE;
          load_d       = 1'b1;
          data_in_d    = shadow_d;
          done_valid_d = 1'b1;
          done_id_d    = cur_id;
          done_count_d = shadow_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      steps_q    <= '0;
      shadow     <= '0;
      ptr        <= '0;
      cur_id     <= '0;
      load       <= 1'b1;
      up_down    <= 1'b0;
      data_in    <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_count <= '0;
      mismatch   <= 1'b0;
    end else begin
      state      <= state_d;
      steps_q    <= steps_d;
      shadow     <= shadow_d;
      ptr        <= ptr_d;
      cur_id     <= cur_id_d;
      load       <= load_d;
      up_down    <= up_down_d;
      data_in    <= data_in_d;
      done_valid <= done_valid_d;
      done_id    <= done_id_d;
      done_count <= done_count_d;
      mismatch   <= mismatch | (count != shadow);
    end
  end

endmodule

// File: tb/tb_count_cmd_sched.sv
module tb_count_cmd_sched;
  import count_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int STEPW = 4;

  logic                  clock = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [4*NREQ-1:0]     req_data;
  logic [STEPW*NREQ-1:0] req_steps;
  logic                  load, up_down, done_valid, busy, mismatch;
  logic [3:0]            data_in, count, done_count;
  logic [1:0]            done_id;

  logic [1:0]       op_a[NREQ];
  logic [3:0]       data_a[NREQ];
  logic [STEPW-1:0] steps_a[NREQ];
  logic [NREQ-1:0]  rv = '0;

  logic [3:0] cnt = '0;
  logic [3:0] off = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  count_cmd_sched #(.NREQ(NREQ), .STEPW(STEPW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_steps  (req_steps),
    .load       (load),
    .up_down    (up_down),
    .data_in    (data_in),
    .count      (count),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_count (done_count),
    .busy       (busy),
    .mismatch   (mismatch)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]         = op_a[i];
      req_data[4*i +: 4]       = data_a[i];
      req_steps[STEPW*i +: STEPW] = steps_a[i];
    end
  end

  // External counter behaviour; off lets the bench skew what the DUT sees.
  always @(posedge clock) begin
    if (!resetn)      cnt <= 4'd0;
    else if (load)    cnt <= data_in;
    else if (up_down) cnt <= cnt + 4'd1;
    else              cnt <= cnt - 4'd1;
  end
  assign count = cnt + off;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    rv = '0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  // Called with inputs already applied and settled; returns accept cycle.
  task automatic wait_accept(input int i, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int k = 0; k < 30; k++) begin
      if (req_ready[i] && rv[i]) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      @(negedge clock);
      #1;
    end
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [3:0] data,
                       input int steps, input int exp_cnt, input int exp_lat);
    int t, d;
    bit ok, got;
    @(negedge clock);
    op_a[i] = op;
    data_a[i] = data;
    steps_a[i] = STEPW'(steps);
    rv[i] = 1'b1;
    #1;
    wait_accept(i, t, ok);
    chk("issue_accept", int'(ok), 1);
    @(negedge clock);
    rv[i] = 1'b0;
    #1;
    if (op == OP_LOAD) begin
      chk("load_pin", int'(load), 1);
      chk("load_data_in", int'(data_in), int'(data));
      chk("load_busy", int'(busy), 1);
    end else if (op != OP_NOP && steps != 0) begin
      chk("step_load_pin", int'(load), 0);
      chk("step_dir", int'(up_down), int'(op == OP_UP));
    end
    got = 1'b0;
    d = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_valid) begin
        got = 1'b1;
        d = cyc;
        break;
      end
      chk("exec_busy", int'(busy), 1);
      @(negedge clock);
      #1;
    end
    chk("done_seen", int'(got), 1);
    if (got) begin
      chk("done_id", int'(done_id), i);
      chk("done_count", int'(done_count), exp_cnt);
      chk("counter_value", int'(count), exp_cnt);
      chk("done_latency", d - t, exp_lat);
      chk("done_busy", int'(busy), 0);
      chk("no_mismatch", int'(mismatch), 0);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    int         steps;
    int         exp_cnt;
    int         exp_lat;
  } vec_t;

  typedef struct {
    int c;
    int id;
    int val;
  } done_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[10];
    done_t dq[$];
    int    g_id[4], g_cyc[4], d_cyc[4], d_cnt[4];
    int    ng, nd, t, m_free, ex_lo, ex_hi, m_ptr, m_val, w, s, dc, nv;
    bit    ok, exp_done;
    logic [NREQ-1:0] prev;

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      data_a[i] = '0;
      steps_a[i] = '0;
    end

    tbl[0] = '{OP_LOAD, 4'd9,  0,  9,  2};
    tbl[1] = '{OP_LOAD, 4'd14, 0,  14, 2};
    tbl[2] = '{OP_UP,   4'd0,  3,  1,  4};
    tbl[3] = '{OP_LOAD, 4'd1,  0,  1,  2};
    tbl[4] = '{OP_DOWN, 4'd0,  2,  15, 3};
    tbl[5] = '{OP_NOP,  4'd7,  0,  15, 1};
    tbl[6] = '{OP_UP,   4'd0,  0,  15, 1};
    tbl[7] = '{OP_DOWN, 4'd0,  15, 0,  16};
    tbl[8] = '{OP_UP,   4'd0,  5,  5,  6};
    tbl[9] = '{OP_DOWN, 4'd0,  0,  5,  1};

    // Reset and idle
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      chk("idle_load", int'(load), 1);
      chk("idle_data_in", int'(data_in), 0);
      chk("idle_count", int'(count), 0);
      chk("idle_done", int'(done_valid), 0);
      chk("idle_mismatch", int'(mismatch), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_ready", int'(req_ready), 0);
      if (k == 0) chk("reset_up_down", int'(up_down), 0);
    end

    // Single-requester command table
    foreach (tbl[n])
      issue(0, tbl[n].op, tbl[n].data, tbl[n].steps, tbl[n].exp_cnt, tbl[n].exp_lat);

    // All requesters contending; req3 load first puts the pointer at 0
    issue(3, OP_LOAD, 4'd13, 0, 13, 2);
    for (int k = 0; k < 4; k++) begin
      g_id[k] = -1; g_cyc[k] = -1; d_cyc[k] = -1; d_cnt[k] = -1;
    end
    ng = 0; nd = 0;
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = OP_UP;
      steps_a[i] = STEPW'(1);
    end
    rv = '1;
    #1;
    for (int k = 0; k < 30 && nd < 4; k++) begin
      if (req_ready != '0 && ng < 4) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) g_id[ng] = j;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (done_valid && nd < 4) begin
        d_cyc[nd] = cyc;
        d_cnt[nd] = int'(done_count);
        nd++;
      end
      prev = req_ready & rv;
      @(negedge clock);
      rv = rv & ~prev;
      #1;
    end
    chk("rr_grants", ng, 4);
    chk("rr_dones", nd, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", g_id[k], k);
      chk("rr_done_count", d_cnt[k], (13 + k + 1) % 16);
      if (k > 0) chk("rr_back_to_back", g_cyc[k], d_cyc[k-1]);
    end
    chk("rr_final_count", int'(count), 1);

    // Reset in the middle of a long UP
    @(negedge clock);
    op_a[1] = OP_UP;
    steps_a[1] = STEPW'(8);
    rv[1] = 1'b1;
    #1;
    wait_accept(1, t, ok);
    chk("mid_accept", int'(ok), 1);
    @(negedge clock);
    rv = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_busy", int'(busy), 1);
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_load", int'(load), 1);
    chk("rst_data_in", int'(data_in), 0);
    chk("rst_busy", int'(busy), 0);
    for (int k = 0; k < 12; k++) begin
      chk("rst_no_done", int'(done_valid), 0);
      chk("rst_idle_busy", int'(busy), 0);
      @(negedge clock);
      #1;
    end
    op_a[2] = OP_NOP;
    rv[2] = 1'b1;
    #1;
    chk("rst_ready_idle", int'(req_ready), 4);
    @(negedge clock);
    rv = '0;
    #1;
    chk("rst_nop_done", int'(done_valid), 1);
    chk("rst_nop_id", int'(done_id), 2);
    chk("rst_nop_count", int'(done_count), 0);

    // Sticky divergence flag
    @(negedge clock);
    off = 4'd1;
    #1;
    chk("mm_before", int'(mismatch), 0);
    @(negedge clock);
    off = 4'd0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("mm_sticky", int'(mismatch), 1);
      @(negedge clock);
      #1;
    end
    do_reset();
    chk("mm_cleared", int'(mismatch), 0);

    // Random contention against a transaction-level model
    do_reset();
    m_free = 0; ex_lo = 1; ex_hi = 0; m_ptr = 0; m_val = 0;
    prev = '0;
    dq.delete();
    for (int it = 0; it < 1500; it++) begin
      @(negedge clock);
      rv = rv & ~prev;
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          op_a[i] = 2'($urandom_range(0, 3));
          data_a[i] = 4'($urandom_range(0, 15));
          steps_a[i] = STEPW'($urandom_range(0, 5));
          rv[i] = 1'b1;
        end
      end
      #1;
      exp_done = (dq.size() > 0 && dq[0].c == cyc);
      chk("rnd_done_valid", int'(done_valid), int'(exp_done));
      if (exp_done) begin
        chk("rnd_done_id", int'(done_id), dq[0].id);
        chk("rnd_done_count", int'(done_count), dq[0].val);
        chk("rnd_count", int'(count), dq[0].val);
        void'(dq.pop_front());
      end
      chk("rnd_busy", int'(busy), int'(cyc >= ex_lo && cyc <= ex_hi));
      chk("rnd_mismatch", int'(mismatch), 0);
      if (cyc >= m_free) begin
        chk("rnd_idle_load", int'(load), 1);
        chk("rnd_idle_data", int'(data_in), m_val);
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && rv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        chk("rnd_ready", int'(req_ready), (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          s = int'(steps_a[w]);
          case (op_a[w])
            OP_LOAD: begin dc = cyc + 2; nv = int'(data_a[w]); end
            OP_UP:   begin dc = cyc + ((s == 0) ? 1 : s + 1); nv = (m_val + s) % 16; end
            OP_DOWN: begin dc = cyc + ((s == 0) ? 1 : s + 1); nv = (m_val + 16 - s) % 16; end
            default: begin dc = cyc + 1; nv = m_val; end
          endcase
          dq.push_back('{dc, w, nv});
          m_free = dc;
          ex_lo = cyc + 1;
          ex_hi = dc - 1;
          m_ptr = (w + 1) % NREQ;
          m_val = nv;
        end
      end else begin
        chk("rnd_ready_busy", int'(req_ready), 0);
      end
      prev = req_ready & rv;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
